// File: rtl/serial_subtractor5b_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and counter sizing.
// Pure declarations; no latency or backpressure of its own.
package serial_subtractor5b_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/serial_subtractor5b_if.sv
// Request/response bundle of the serial subtractor; the master issues start plus operands.
// start is sampled only while the block is idle; results hold until the next accepted start.
interface serial_subtractor5b_if #(
  parameter int WIDTH = 5
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             b_in;
  logic [WIDTH-1:0] d;
  logic             b_out;
  logic             ovf;
  logic             busy;
  logic             done;

  modport master (
    output start, a, b, b_in,
    input  d, b_out, ovf, busy, done
  );

  modport slave (
    input  start, a, b, b_in,
    output d, b_out, ovf, busy, done
  );
endinterface

// File: rtl/serial_subtractor5b_full_subtractor.sv
// One-bit full subtractor: d = x - y - bi, with borrow out. Combinational, no backpressure.
module serial_subtractor5b_full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);
  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);
endmodule

// File: rtl/serial_subtractor5b.sv
// Bit-serial subtractor d = a - b - b_in, LSB first; done pulses WIDTH+1 cycles after the start cycle.
// start is ignored while busy or in the done cycle; one operation per WIDTH+2 cycles.
module serial_subtractor5b
  import serial_subtractor5b_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input logic                  clk,
  input logic                  rst,
  serial_subtractor5b_if.slave bus
);

  localparam int             CW   = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] d_sr;
  logic             br;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] d_r;
  logic             b_out_r;
  logic             ovf_r;
  logic             busy_r;
  logic             done_r;

  logic             fs_d;
  logic             fs_bo;

  serial_subtractor5b_full_subtractor u_fs (
    .x  (a_sr[0]),
    .y  (b_sr[0]),
    .bi (br),
    .d  (fs_d),
    .bo (fs_bo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      a_sr    <= '0;
      b_sr    <= '0;
      d_sr    <= '0;
      br      <= 1'b0;
      cnt     <= '0;
      d_r     <= '0;
      b_out_r <= 1'b0;
      ovf_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            a_sr   <= bus.a;
            b_sr   <= bus.b;
            br     <= bus.b_in;
            cnt    <= '0;
            busy_r <= 1'b1;
            state  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          d_sr <= {fs_d, d_sr[WIDTH-1:1]};
          br   <= fs_bo;
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          cnt  <= cnt + 1'b1;
          // On the last bit a_sr[0]/b_sr[0] are the operand sign bits and fs_d is the result sign.
          if (cnt == LAST) begin
            d_r     <= {fs_d, d_sr[WIDTH-1:1]};
            b_out_r <= fs_bo;
            ovf_r   <= (a_sr[0] != b_sr[0]) && (fs_d != a_sr[0]);
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          done_r <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.d     = d_r;
  assign bus.b_out = b_out_r;
  assign bus.ovf   = ovf_r;
  assign bus.busy  = busy_r;
  assign bus.done  = done_r;

endmodule

// File: tb/tb_serial_subtractor5b.sv
// Randomized bench for serial_subtractor5b against an integer-arithmetic reference model.
module tb_serial_subtractor5b;

  localparam int W = 5;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   done_cnt;

  logic [W-1:0] last_d;
  logic         last_bo;
  logic         last_ov;

  serial_subtractor5b_if #(.WIDTH(W)) bus ();

  serial_subtractor5b #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (bus.done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference: unsigned and signed integer subtraction, reduced mod 2^W.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                       output logic [W-1:0] d, output logic bo, output logic ov);
    int ua, ub, ud, sa, sb, sd;
    ua = int'(a);
    ub = int'(b);
    ud = ua - ub - int'(bin);
    sa = (ua >= (1 << (W - 1))) ? ua - (1 << W) : ua;
    sb = (ub >= (1 << (W - 1))) ? ub - (1 << W) : ub;
    sd = sa - sb - int'(bin);
    d  = W'(ud);
    bo = (ud < 0);
    ov = (sd < -(1 << (W - 1))) || (sd > (1 << (W - 1)) - 1);
  endtask

  task automatic drive_noise();
    bus.start = 1'($urandom_range(0, 1));
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    bus.b_in  = 1'($urandom_range(0, 1));
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        input bit noisy, input string tag);
    logic [W-1:0] ed;
    logic         ebo;
    logic         eov;
    int           lat;
    int           dc0;
    model(a, b, bin, ed, ebo, eov);
    @(negedge clk);
    dc0       = done_cnt;
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.b_in  = bin;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    chk({tag, "_busy"}, int'(bus.busy), 1);
    chk({tag, "_hold_d"}, int'(bus.d), int'(last_d));
    chk({tag, "_hold_bo"}, int'(bus.b_out), int'(last_bo));
    while (bus.done !== 1'b1 && lat < 20) begin
      if (noisy) drive_noise();
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, lat, W + 1);
    chk({tag, "_d"}, int'(bus.d), int'(ed));
    chk({tag, "_b_out"}, int'(bus.b_out), int'(ebo));
    chk({tag, "_ovf"}, int'(bus.ovf), int'(eov));
    chk({tag, "_busy_done"}, int'(bus.busy), 0);
    if (noisy) drive_noise();
    @(negedge clk);
    bus.start = 1'b0;
    chk({tag, "_done_pulse"}, int'(bus.done), 0);
    chk({tag, "_done_count"}, done_cnt - dc0, 1);
    last_d  = ed;
    last_bo = ebo;
    last_ov = eov;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int dc0;
    checks    = 0;
    failures  = 0;
    done_cnt  = 0;
    last_d    = '0;
    last_bo   = 1'b0;
    last_ov   = 1'b0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.b_in  = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_d", int'(bus.d), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_bo_ovf", int'({bus.b_out, bus.ovf}), 0);
    rst = 1'b0;

    run_op(5'b10101, 5'b01010, 1'b0, 1'b0, "t1");
    run_op(5'b01010, 5'b10101, 1'b0, 1'b0, "t2");
    run_op(5'b00000, 5'b00000, 1'b1, 1'b0, "t3");
    run_op(5'b01111, 5'b10000, 1'b0, 1'b0, "t4a");
    run_op(5'b00011, 5'b00001, 1'b0, 1'b0, "t4b");
    run_op(5'b10110, 5'b00111, 1'b1, 1'b1, "t5");
    repeat (4) @(negedge clk);
    chk("t5_idle_hold", int'(bus.d), int'(last_d));

    // Abort mid-shift: outputs clear and no done may follow.
    @(negedge clk);
    dc0       = done_cnt;
    bus.start = 1'b1;
    bus.a     = 5'b11011;
    bus.b     = 5'b00100;
    bus.b_in  = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6_rst_d", int'(bus.d), 0);
    chk("t6_rst_busy", int'(bus.busy), 0);
    chk("t6_rst_bo_ovf", int'({bus.b_out, bus.ovf}), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("t6_no_done", done_cnt - dc0, 0);
    last_d  = '0;
    last_bo = 1'b0;
    last_ov = 1'b0;
    run_op(5'b11111, 5'b00001, 1'b0, 1'b0, "t6");

    for (int i = 0; i < 1000; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 1) == 1), "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
